// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path that drains the TX FIFO.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_tx_fifo_reader_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic bit_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Pops words from the TX FIFO and serializes them as start/data/[parity]/stop UART frames.
// Define UART_TX_STOP2_EN for two stop bits per frame.
module uart_tx_fifo_reader
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_EN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RD_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  stop_last;
  logic                  pop_cond;
  logic                  restart;

`ifdef UART_TX_STOP2_EN
  // bit_idx counts stop bits while in STOP
  assign stop_last = (bit_idx_q == IDX_W'(1));
`else
  assign stop_last = 1'b1;
`endif

  assign pop_cond = ~RST & TX_EN & ~FIFO_EMPTY &
                    ((state_q == IDLE) | ((state_q == STOP) & bit_done & stop_last));
  assign FIFO_RD_INC = pop_cond;

  // Hold the timer at zero while idle so a new frame always starts a full bit period.
  assign restart = (state_q == IDLE) | pop_cond;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .restart  (restart),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            bit_idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          bit_idx_d = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!stop_last) begin
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A pop overrides the STOP->IDLE exit so frames run back to back.
    if (pop_cond) begin
      state_d   = START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      shift_d   = FIFO_RD_DATA;
      par_en_d  = PAR_EN;
      par_bit_d = (^FIFO_RD_DATA) ^ (PAR_TYP == PAR_ODD);
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- Downstream consumer of the TX-side async FIFO, in the read clock domain.
- Pops one word whenever the FIFO is non-empty and the transmitter is free.
- Serializes the word onto the UART line: start bit, data LSB-first, optional parity, stop bit.
- Supports back-to-back frames with no idle gap between them.

Parameters:
- DATA_WIDTH, 8, width of each FIFO word and UART data field.
- CLKS_PER_BIT, 16, CLK cycles per UART bit; must be ≥2.
- CNT_W, 8, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- CLK  input  1  read-domain clock.
- RST  input  1  synchronous, active-high reset.
- TX_EN  input  1  allows a new pop/frame start; a frame already in flight always completes.
- PAR_EN  input  1  1 = parity bit inserted.
- PAR_TYP  input  1  0 = even, 1 = odd.
- FIFO_RD_DATA  input  DATA_WIDTH  FIFO head word; valid combinationally while FIFO_EMPTY=0.
- FIFO_EMPTY  input  1  1 = FIFO empty; already synchronized into the CLK domain.
- FIFO_RD_INC  output  1  single-cycle pop strobe.
- TX_OUT  output  1  serial line; idle high.
- BUSY  output  1  high from the cycle after a pop until the last stop-bit cycle, inclusive.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - next state IDLE; TX_OUT=1, BUSY=0, FIFO_RD_INC=0.
  - bit counter, cycle counter and shift register cleared.
  - Mid-frame reset aborts the frame immediately with no pop; the aborted word is lost.
- All outputs are registered except FIFO_RD_INC.
- FIFO_RD_INC = pop_cond, where pop_cond = TX_EN & ~FIFO_EMPTY & (state==IDLE | last cycle of STOP). It is never asserted while FIFO_EMPTY=1.
- On a pop edge:
  - shift reg <= FIFO_RD_DATA.
  - PAR_EN/PAR_TYP latched for the whole frame.
  - parity = ^data XOR PAR_TYP.
  - state <= START; TX_OUT <= 0.
- State machine:
  - IDLE: TX_OUT=1; leave only on pop.
  - START: TX_OUT=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..DATA_WIDTH-1. After the last bit, go to PARITY if latched PAR_EN, else STOP.
  - PARITY: one bit period.
  - STOP: TX_OUT=1 for one bit period. In its last cycle, if pop_cond then pop and go to START (no idle bit between frames); else go to IDLE.
- Cycle counter runs 0..CLKS_PER_BIT-1 and wraps; bit transitions occur on the wrap.
- Frame length = (2 + DATA_WIDTH + PAR_EN) × CLKS_PER_BIT cycles.
- Latency: the pop cycle is t; the start bit appears on TX_OUT from edge t+1.
- TX_EN deasserted mid-frame: the current frame finishes; no further pop.
- FIFO_EMPTY rising mid-frame: ignored until the next pop decision.

Optional Feature:
- Macro UART_TX_STOP2_EN.
  - Defined: the STOP state lasts 2×CLKS_PER_BIT cycles; the pop decision is made in the final cycle of the second stop bit; frame length grows by CLKS_PER_BIT.
  - Undefined: one stop bit exactly as above; no extra logic synthesized.

Decomposition:
- Package uart_tx_pkg holds:
  - state encoding constants IDLE/START/DATA/PARITY/STOP (3 bits).
  - PAR_EVEN=0, PAR_ODD=1.
  - the default CLKS_PER_BIT.
- Sub-module uart_bit_timer holds the cycle counter.
  - Inputs: CLK, RST, restart.
  - Output: bit_done, pulsed in the last cycle of each bit period.
  - The FSM, shifter and parity stay in the top module.

Test Plan:
- Single frame (CLKS_PER_BIT=4, PAR_EN=0): FIFO holds 0xA5, TX_EN=1.
  - FIFO_RD_INC is high for exactly 1 cycle.
  - TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total), then idle high.
  - BUSY high for 40 cycles.
- Parity: 0x07 with even parity → parity bit 1; with odd parity → 0. Frame is 44 cycles.
- Back-to-back: FIFO holds 0x55, 0xFF.
  - Second pop occurs in the last cycle of the first STOP.
  - Start bit of frame 2 immediately follows the stop bit; no idle cycles; exactly 2 pops.
- Empty/disable:
  - FIFO_EMPTY=1 for 100 cycles → no pop, TX_OUT=1.
  - TX_EN dropped during DATA → frame completes, then no pop despite a non-empty FIFO.
- Reset mid-frame: RST=1 during DATA bit 3.
  - Next edge: TX_OUT=1, BUSY=0, state IDLE.
  - After RST drops, the next pop resumes with a fresh frame.
- UART_TX_STOP2_EN defined: 0xA5, no parity → stop high for 8 cycles; total 44 cycles.
